// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Stalls the pipeline while an operation runs; result is held until the next start.
module ex_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              neg_rem;
    logic [2*XLEN-1:0] acc;

    logic              sgn1;
    logic              sgn2;
    logic              neg1;
    logic              neg2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   fast_res;

    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        sgn1     = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1     = sgn1 && rs1[XLEN-1];
        neg2     = sgn2 && rs2[XLEN-1];
        abs1     = neg1 ? -rs1 : rs1;
        abs2     = neg2 ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2 == '1);
        fast_res = '0;
        if (div_zero)
            fast_res = funct3[1] ? rs1 : '1;
        else if (div_ovf)
            fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Multiply: acc = {partial, multiplier}, add-then-shift-right.
    // Divide:   acc = {remainder, dividend->quotient}, restoring shift-subtract.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_rem  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_rem - {1'b0, mag_b};
        if (!op[2])
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {div_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        prod = neg_res ? -acc_nxt : acc_nxt;
        quo  = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fin_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo;
            default:                fin_res = rem;
        endcase
    end

    always_comb begin
        stall = ((state == IDLE) && start && !flush) || (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            op      <= funct3;
                            mag_a   <= abs1;
                            mag_b   <= abs2;
                            neg_res <= neg1 ^ neg2;
                            neg_rem <= neg1;
                            acc     <= funct3[2] ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
                            cnt     <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result <= fin_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors with hand-computed results,
// a monitor compares every done pulse against the queued expectation and cycle.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   asserts = 0;
    int   fails = 0;
    int   next_id = 0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("result_op%0d", e.id), result, e.res);
                check($sformatf("done_cycle_op%0d", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one op, expect done after lat cycles and stall high for lat cycles.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        exp_t e;
        int   n;
        int   stall_cnt;
        bit   got;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        e.res = exp; e.cyc = cyc + lat; e.id = next_id;
        next_id++;
        sb.push_back(e);
        n = 0; stall_cnt = 0; got = 1'b0;
        while (1) begin
            #1;
            if (stall) stall_cnt++;
            if (done) got = 1'b1;
            if (got || n >= 100) break;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        check($sformatf("done_seen_op%0d", e.id), 32'(got), 32'd1);
        check($sformatf("stall_cycles_op%0d", e.id), 32'(stall_cnt), 32'(lat));
    endtask

    task automatic expect_no_done(input string name, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   n;
        reset = 1'b0; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // multiplies
        run_op(3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33);
        run_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
        run_op(3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33);
        run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        // divides
        run_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        run_op(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        run_op(3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op(3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33);
        // fast paths
        run_op(3'b101, 32'h00001234, 32'h0, 32'hFFFFFFFF, 1);
        run_op(3'b110, 32'h00001234, 32'h0, 32'h00001234, 1);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

        // flush in RUN cycle 5 with a simultaneous start
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_stall_after", {31'b0, stall}, 32'h0);
        expect_no_done("flush_no_done", 40);
        check("flush_result_kept", result, 32'h80000000);

        // flush overriding start while idle
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        expect_no_done("idle_flush_no_done", 40);

        // back-to-back with start held; operands changed mid-RUN for the second op
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'h12345678; rs2 = 32'd9;
        e1.res = 32'hA3D70A38; e1.cyc = cyc + 33; e1.id = next_id; next_id++;
        e2.res = 32'h0000002A; e2.cyc = cyc + 67; e2.id = next_id; next_id++;
        sb.push_back(e1);
        sb.push_back(e2);
        repeat (5) @(negedge clk);
        rs1 = 32'd7; rs2 = 32'd6;
        n = 0;
        while (sb.size() != 0 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("b2b_completed", 32'(sb.size()), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-RUN
        run_op(3'b011, 32'h00000010, 32'h00000010, 32'h00000000, 33);
        run_op(3'b000, 32'h00000010, 32'h00000010, 32'h00000100, 33);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrun_reset_result", result, 32'h0);
        check("midrun_reset_stall", {31'b0, stall}, 32'h0);
        check("midrun_reset_done", {31'b0, done}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expect_no_done("midrun_reset_no_done", 40);
        check("final_result_after_reset", result, 32'h0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
